// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults and sizing helper for the FIFO stream reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_stream_reader_pkg;

    // Smallest w with 2**w >= v; sizes the line word counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_N        = 16;
    localparam int DEF_LINE_LEN = 640;
    localparam int DEF_CNT_W    = clog2(DEF_LINE_LEN);

    // Buffer occupancy, 0..2.
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus framed output stream, grouped for the reader.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the stream consumer.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int N = DEF_N
);
    logic         fifo_empty;
    logic [N-1:0] fifo_rd_data;
    logic         fifo_rd_en;
    logic         flush;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_first;
    logic         out_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  flush,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_valid,
        output out_first,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output flush,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last
    );

endinterface

// File: rtl/fifo_stream_reader_fifo_rd_buf.sv
// Two-entry in-order buffer catching FIFO read data; head is entry 0.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must never push into a full buffer without popping.
module fifo_rd_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [N-1:0] i_push_dat,
    input  logic         i_pop,
    output occ_t         o_occ,
    output logic [N-1:0] o_head_dat
);

    occ_t         r_occ;
    logic [N-1:0] r_ent0;
    logic [N-1:0] r_ent1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else if (i_flush) begin
            r_occ <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_ent0 <= i_push_dat;
                    else               r_ent1 <= i_push_dat;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy holds; the new word lands behind whatever remains.
                    if (r_occ == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_dat;
                    end else begin
                        r_ent0 <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ      = r_occ;
    assign o_head_dat = r_ent0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream with first/last line framing.
// Latency: FIFO non-empty to out_valid is 2 cycles; sustains 1 word/cycle.
// Backpressure: reads are issued only while buffered + in-flight words stay within 2.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int LINE_LEN = DEF_LINE_LEN,
    parameter int CNT_W    = clog2(LINE_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_stream_reader_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);

    logic             r_inflight;
    logic [CNT_W-1:0] r_word_idx;

    occ_t             w_occ;
    logic [N-1:0]     w_head;
    logic             w_valid;
    logic             w_pop;
    logic             w_room;
    logic             w_rd_en;
    logic             w_push;

    assign w_valid = rst_n & (w_occ != 2'd0);
    assign w_pop   = w_valid & bus.out_ready;

    // A word popped this cycle frees its slot in time for a read issued now.
    assign w_room  = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_rd_en = rst_n & ~bus.flush & ~bus.fifo_empty & w_room;
    assign w_push  = r_inflight & ~bus.flush;

    fifo_rd_buf #(
        .N (N)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (bus.flush),
        .i_push     (w_push),
        .i_push_dat (bus.fifo_rd_data),
        .i_pop      (w_pop),
        .o_occ      (w_occ),
        .o_head_dat (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_inflight <= 1'b0;
        else        r_inflight <= w_rd_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_word_idx <= '0;
        end else if (w_pop) begin
            r_word_idx <= (r_word_idx == LAST_IDX) ? '0 : r_word_idx + CNT_W'(1);
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_valid  = w_valid;
    assign bus.out_data   = w_head;
    assign bus.out_first  = w_valid & (r_word_idx == '0);
    assign bus.out_last   = w_valid & (r_word_idx == LAST_IDX);

endmodule
